// File: rtl/uc_gera_asteroides.sv
`default_nettype none
// ============================================================================
// Module      : uc_gera_asteroides
// Description : Asteroid spawner. Scans the asteroid memory for the lowest
//               free slot and writes a new LFSR-derived entry into it.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_gera_asteroides #(
    parameter int         N_ASTE    = 16,
    parameter int         ADDR_W    = 4,
    parameter int         COORD_W   = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               gera_aste,
    input  logic               loaded_aste,
    output logic [ADDR_W-1:0]  addr_aste,
    output logic               we_aste,
    output logic               loaded_w_aste,
    output logic [1:0]         opcode_w_aste,
    output logic [COORD_W-1:0] pos_x_w_aste,
    output logic [COORD_W-1:0] pos_y_w_aste,
    output logic               geracao_concluida_aste,
    output logic               sem_espaco_aste,
    output logic [4:0]         db_estado_gera_aste
);

    localparam logic [ADDR_W-1:0]  C_LAST_SLOT = ADDR_W'(N_ASTE - 1);
    localparam logic [COORD_W-1:0] C_COORD_MAX = '1;

    typedef enum logic [3:0] {
        INICIO          = 4'd0,
        ESPERA          = 4'd1,
        RESETA_CONTADOR = 4'd2,
        VERIFICA_LOADED = 4'd3,
        SORTEIA         = 4'd4,
        ESCREVE         = 4'd5,
        INCREMENTA      = 4'd6,
        AUX             = 4'd7,
        SINALIZA        = 4'd8,
        CHEIO           = 4'd9
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic [1:0]           opc_q, opc_d;
    logic [COORD_W-1:0]   r_q, r_d;
    logic                 rco;

    assign rco = (cnt_q == C_LAST_SLOT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opc_d   = opc_q;
        r_d     = r_q;
        // Fibonacci x^8+x^6+x^5+x^4+1, free-running in every state
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        case (state_q)
            INICIO:          state_d = ESPERA;
            ESPERA:          if (gera_aste) state_d = RESETA_CONTADOR;
            RESETA_CONTADOR: begin
                cnt_d   = '0;
                state_d = VERIFICA_LOADED;
            end
            VERIFICA_LOADED: begin
                if (!loaded_aste) state_d = SORTEIA;
                else if (rco)     state_d = CHEIO;
                else              state_d = INCREMENTA;
            end
            SORTEIA: begin
                opc_d   = lfsr_q[1:0];
                r_d     = lfsr_q[COORD_W+1:2];
                state_d = ESCREVE;
            end
            ESCREVE:         state_d = SINALIZA;
            INCREMENTA: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = AUX;
            end
            AUX:             state_d = VERIFICA_LOADED;
            SINALIZA:        state_d = ESPERA;
            CHEIO:           state_d = ESPERA;
            default:         state_d = INICIO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= INICIO;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            opc_q   <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            opc_q   <= opc_d;
            r_q     <= r_d;
        end
    end

    // Moore decode: every output is a function of registered state only
    always_comb begin
        addr_aste              = cnt_q;
        we_aste                = 1'b0;
        loaded_w_aste          = 1'b0;
        opcode_w_aste          = 2'b00;
        pos_x_w_aste           = '0;
        pos_y_w_aste           = '0;
        geracao_concluida_aste = 1'b0;
        sem_espaco_aste        = 1'b0;
        db_estado_gera_aste    = {1'b0, state_q};
        case (state_q)
            INICIO, ESPERA, RESETA_CONTADOR, VERIFICA_LOADED,
            SORTEIA, INCREMENTA, AUX: begin
            end
            ESCREVE: begin
                we_aste       = 1'b1;
                loaded_w_aste = 1'b1;
                opcode_w_aste = opc_q;
                // enter from the edge opposite the direction of motion
                case (opc_q)
                    2'b00: begin pos_x_w_aste = '0;          pos_y_w_aste = r_q;         end
                    2'b01: begin pos_x_w_aste = C_COORD_MAX; pos_y_w_aste = r_q;         end
                    2'b10: begin pos_x_w_aste = r_q;         pos_y_w_aste = '0;          end
                    default: begin pos_x_w_aste = r_q;       pos_y_w_aste = C_COORD_MAX; end
                endcase
            end
            SINALIZA: geracao_concluida_aste = 1'b1;
            CHEIO:    sem_espaco_aste        = 1'b1;
            default:  db_estado_gera_aste    = 5'd31;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uc_gera_asteroides.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uc_gera_asteroides
// Description : Directed table-driven bench for the asteroid spawner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uc_gera_asteroides;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       gera_aste = 1'b0;
    logic       loaded_aste;
    logic [3:0] addr_aste;
    logic       we_aste;
    logic       loaded_w_aste;
    logic [1:0] opcode_w_aste;
    logic [3:0] pos_x_w_aste;
    logic [3:0] pos_y_w_aste;
    logic       geracao_concluida_aste;
    logic       sem_espaco_aste;
    logic [4:0] db_estado_gera_aste;

    logic [15:0] mem = '0;
    logic [7:0]  lf_m;
    logic [3:0]  opc_seen = '0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [15:0] mask;
        int          addr;
        int          cyc;
        bit          full;
        bit          toggle;
    } vec_t;

    vec_t vecs[7];

    uc_gera_asteroides #(
        .N_ASTE(16), .ADDR_W(4), .COORD_W(4), .LFSR_SEED(8'hA5)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .gera_aste              (gera_aste),
        .loaded_aste            (loaded_aste),
        .addr_aste              (addr_aste),
        .we_aste                (we_aste),
        .loaded_w_aste          (loaded_w_aste),
        .opcode_w_aste          (opcode_w_aste),
        .pos_x_w_aste           (pos_x_w_aste),
        .pos_y_w_aste           (pos_y_w_aste),
        .geracao_concluida_aste (geracao_concluida_aste),
        .sem_espaco_aste        (sem_espaco_aste),
        .db_estado_gera_aste    (db_estado_gera_aste)
    );

    always #5 clock = ~clock;

    assign loaded_aste = mem[addr_aste];

    always @(posedge clock) if (reset && we_aste) mem[addr_aste] <= 1'b1;

    always @(posedge clock or negedge reset) begin
        if (!reset) lf_m <= 8'hA5;
        else        lf_m <= {lf_m[6:0], lf_m[7] ^ lf_m[5] ^ lf_m[4] ^ lf_m[3]};
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_espera(input string tag);
        int n = 0;
        while (db_estado_gera_aste != 5'd1 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_reach_espera"}, int'(db_estado_gera_aste), 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int we_cyc = -1, we_cnt = 0, done_cyc = -1, done_cnt = 0;
        int full_cyc = -1, full_cnt = 0, wr_addr = -1, bad_addr = 0, bad_idle = 0;
        logic [7:0] lf_s = '0;
        logic [3:0] r, ex, ey;
        mem = v.mask;
        wait_espera(tag);
        gera_aste = 1'b1;
        tick();
        gera_aste = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (v.toggle && k <= 6) gera_aste = k[0];
            if (db_estado_gera_aste == 5'd4) lf_s = lf_m;
            if (we_aste) begin
                we_cnt++;
                if (we_cyc < 0) begin
                    we_cyc  = k + 1;
                    wr_addr = int'(addr_aste);
                    r = lf_s[5:2];
                    case (lf_s[1:0])
                        2'b00: begin ex = 4'd0;  ey = r;     end
                        2'b01: begin ex = 4'd15; ey = r;     end
                        2'b10: begin ex = r;     ey = 4'd0;  end
                        default: begin ex = r;   ey = 4'd15; end
                    endcase
                    opc_seen[opcode_w_aste] = 1'b1;
                    chk({tag, "_opcode"}, int'(opcode_w_aste), int'(lf_s[1:0]));
                    chk({tag, "_pos_x"}, int'(pos_x_w_aste), int'(ex));
                    chk({tag, "_pos_y"}, int'(pos_y_w_aste), int'(ey));
                    chk({tag, "_loaded_w"}, int'(loaded_w_aste), 1);
                end
            end else if (loaded_w_aste || opcode_w_aste != 0 ||
                         pos_x_w_aste != 0 || pos_y_w_aste != 0) begin
                bad_idle++;
            end
            if (geracao_concluida_aste) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k + 1;
                if (int'(addr_aste) != wr_addr) bad_addr++;
            end
            if (sem_espaco_aste) begin
                full_cnt++;
                if (full_cyc < 0) full_cyc = k + 1;
            end
        end
        gera_aste = 1'b0;
        chk({tag, "_we_count"}, we_cnt, v.full ? 0 : 1);
        chk({tag, "_idle_data_zero"}, bad_idle, 0);
        chk({tag, "_db_after"}, int'(db_estado_gera_aste), 1);
        if (v.full) begin
            chk({tag, "_full_cycle"}, full_cyc, v.cyc);
            chk({tag, "_full_count"}, full_cnt, 1);
            chk({tag, "_done_count"}, done_cnt, 0);
            chk({tag, "_mem"}, int'(mem), int'(v.mask));
        end else begin
            chk({tag, "_we_cycle"}, we_cyc, v.cyc);
            chk({tag, "_addr"}, wr_addr, v.addr);
            chk({tag, "_done_cycle"}, done_cyc, v.cyc + 1);
            chk({tag, "_done_count"}, done_cnt, 1);
            chk({tag, "_addr_hold"}, bad_addr, 0);
            chk({tag, "_full_count"}, full_cnt, 0);
            chk({tag, "_mem"}, int'(mem), int'(v.mask | (16'h1 << v.addr)));
        end
    endtask

    initial begin
        int         n;
        int         w_addr[3];
        vec_t       v0;

        //            mask      addr cyc full toggle
        vecs[0] = '{16'h0000,  0,   4,  1'b0, 1'b0};
        vecs[1] = '{16'h0007,  3,  13,  1'b0, 1'b0};
        vecs[2] = '{16'hFFFF,  0,  48,  1'b1, 1'b0};
        vecs[3] = '{16'h0001,  1,   7,  1'b0, 1'b1};
        vecs[4] = '{16'h7FFF, 15,  49,  1'b0, 1'b0};
        vecs[5] = '{16'h00F7,  3,  13,  1'b0, 1'b1};
        vecs[6] = '{16'hFFFF,  0,  48,  1'b1, 1'b1};

        // reset
        #2 reset = 1'b0;
        tick();
        tick();
        chk("reset_db", int'(db_estado_gera_aste), 0);
        chk("reset_addr", int'(addr_aste), 0);
        chk("reset_outputs", int'({we_aste, loaded_w_aste, opcode_w_aste, pos_x_w_aste,
                                   pos_y_w_aste, geracao_concluida_aste, sem_espaco_aste}), 0);
        reset = 1'b1;
        tick();
        chk("inicio_to_espera", int'(db_estado_gera_aste), 1);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // keep spawning into an empty memory until every direction has appeared
        v0 = '{16'h0000, 0, 4, 1'b0, 1'b0};
        n = 0;
        while (opc_seen != 4'hF && n < 40) begin
            run_vec(v0, "opc_sweep");
            n++;
        end
        chk("all_opcodes_seen", int'(opc_seen), 15);

        // request held high fills consecutive slots
        mem = '0;
        wait_espera("held");
        gera_aste = 1'b1;
        n = 0;
        for (int k = 0; k < 120 && n < 3; k++) begin
            tick();
            if (we_aste) begin
                w_addr[n] = int'(addr_aste);
                n++;
                if (n == 3) gera_aste = 1'b0;
            end
        end
        gera_aste = 1'b0;
        wait_espera("held_end");
        chk("held_writes", n, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("held_addr%0d", i), (i < n) ? w_addr[i] : -1, i);
        chk("held_mem", int'(mem), 7);

        // reset while in escreve
        mem = '0;
        wait_espera("rst_escreve");
        gera_aste = 1'b1;
        tick();
        gera_aste = 1'b0;
        n = 0;
        while (!we_aste && n < 20) begin tick(); n++; end
        chk("rst_escreve_reached", int'(we_aste), 1);
        reset = 1'b0;
        #1;
        chk("rst_escreve_we", int'(we_aste), 0);
        chk("rst_escreve_db", int'(db_estado_gera_aste), 0);
        chk("rst_escreve_addr", int'(addr_aste), 0);
        tick();
        reset = 1'b1;
        wait_espera("rst_escreve_rel");
        repeat (5) tick();
        chk("rst_escreve_mem", int'(mem), 0);

        // reset while in aux, after the counter has advanced
        mem = 16'h0001;
        wait_espera("rst_aux");
        gera_aste = 1'b1;
        tick();
        gera_aste = 1'b0;
        n = 0;
        while (db_estado_gera_aste != 5'd7 && n < 20) begin tick(); n++; end
        chk("rst_aux_reached", int'(db_estado_gera_aste), 7);
        chk("rst_aux_addr_before", int'(addr_aste), 1);
        reset = 1'b0;
        #1;
        chk("rst_aux_db", int'(db_estado_gera_aste), 0);
        chk("rst_aux_addr", int'(addr_aste), 0);
        chk("rst_aux_we", int'(we_aste), 0);
        tick();
        reset = 1'b1;
        wait_espera("rst_aux_rel");
        repeat (5) tick();
        chk("rst_aux_mem", int'(mem), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
